// File: rtl/instr_fetch_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_mem_if
//  Description : Load and fetch port bundle for instr_fetch_mem. The master
//                side drives program bytes and fetch requests. The slave side
//                (the memory) returns instructions and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_mem_if #(
  parameter int INSTR_W = 16,
  parameter int CELL_W  = 8,
  parameter int AW      = 8
);
  logic              load_valid;
  logic              load_ready;
  logic [CELL_W-1:0] load_data;
  logic              load_last;
  logic              reload;
  logic              fetch_req;
  logic [AW-1:0]     fetch_addr;
  logic              fetch_stall;
  logic [INSTR_W-1:0] instr;
  logic              instr_valid;
  logic [1:0]        fault_code;
  logic [AW:0]       prog_len;
  logic              running;

  modport master (
    output load_valid, load_data, load_last, reload,
    output fetch_req, fetch_addr, fetch_stall,
    input  load_ready, instr, instr_valid, fault_code, prog_len, running
  );

  modport slave (
    input  load_valid, load_data, load_last, reload,
    input  fetch_req, fetch_addr, fetch_stall,
    output load_ready, instr, instr_valid, fault_code, prog_len, running
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_mem.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_mem
//  Description : Byte-organised instruction memory. A program is streamed in
//                through a load port. Instructions are then fetched
//                big-endian through a registered fetch port that has
//                stall hold and fault detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_mem #(
  parameter int                 INSTR_W = 16,
  parameter int                 CELL_W  = 8,
  parameter int                 DEPTH   = 256,
  parameter logic [INSTR_W-1:0] NOP     = '0
) (
  input  logic             clk,
  input  logic             rst,
  instr_fetch_mem_if.slave bus
);

  localparam int              NB     = INSTR_W / CELL_W;
  localparam int              AW     = $clog2(DEPTH);
  localparam logic [AW-1:0]   NB_A   = AW'(NB);
  localparam logic [AW:0]     NB_EXT = (AW+1)'(NB);
  localparam logic [AW:0]     ONE_EXT = (AW+1)'(1);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [0:0] {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CELL_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW:0]         prog_len;
  logic                load_ready;
  logic                running;
  logic [INSTR_W-1:0]  instr;
  logic                instr_valid;
  logic [1:0]          fault_code;
  logic [INSTR_W-1:0]  rd_word;
  logic                accept;
  logic                load_done;
  logic                misaligned;
  logic                out_of_range;

  // Held in reset, a byte is never accepted, so reset also aborts a load mid-stream.
  assign accept    = load_ready && bus.load_valid && !rst;
  assign load_done = accept && (bus.load_last || wptr == LAST_ADDR);

  assign misaligned   = (bus.fetch_addr % NB_A) != '0;
  assign out_of_range = ({1'b0, bus.fetch_addr} + NB_EXT) > prog_len;

  // Assemble the instruction big-endian: the lowest address goes in the MSBs.
  for (genvar i = 0; i < NB; i++) begin : g_cells
    logic [AW-1:0] idx;
    assign idx = bus.fetch_addr + AW'(i);
    assign rd_word[INSTR_W-1-i*CELL_W -: CELL_W] = mem[idx];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    running    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        running = 1'b1;
        if (bus.reload) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Memory array write. It has no reset, so the contents survive rst.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= bus.load_data;
  end

  // Write pointer and program length. The length is one bit wider so a full memory reports DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      prog_len <= '0;
    end else if (state_q == ST_RUN && bus.reload) begin
      wptr     <= '0;
      prog_len <= '0;
    end else if (accept) begin
      wptr <= wptr + AW'(1);
      if (load_done) prog_len <= {1'b0, wptr} + ONE_EXT;
    end
  end

  // Registered fetch port. reload beats stall, stall beats fetch_req, and faults force NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= NOP;
      instr_valid <= 1'b0;
      fault_code  <= 2'b00;
    end else if (state_q == ST_RUN && bus.reload) begin
      if (bus.fetch_req && !bus.fetch_stall) begin
        instr       <= NOP;
        instr_valid <= 1'b1;
        fault_code  <= 2'b11;
      end else begin
        instr_valid <= 1'b0;
      end
    end else if (!bus.fetch_stall) begin
      if (!bus.fetch_req) begin
        instr_valid <= 1'b0;
      end else if (state_q == ST_LOAD) begin
        instr       <= NOP;
        instr_valid <= 1'b1;
        fault_code  <= 2'b11;
      end else if (misaligned) begin
        instr       <= NOP;
        instr_valid <= 1'b1;
        fault_code  <= 2'b01;
      end else if (out_of_range) begin
        instr       <= NOP;
        instr_valid <= 1'b1;
        fault_code  <= 2'b10;
      end else begin
        instr       <= rd_word;
        instr_valid <= 1'b1;
        fault_code  <= 2'b00;
      end
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.running     = running;
  assign bus.prog_len    = prog_len;
  assign bus.instr       = instr;
  assign bus.instr_valid = instr_valid;
  assign bus.fault_code  = fault_code;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_mem
//  Description : Directed self-checking bench for instr_fetch_mem. It covers
//                load, fetch, faults, stall hold, full-depth load, reset
//                mid-load and reload.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  instr_fetch_mem_if #(.INSTR_W(16), .CELL_W(8), .AW(8)) bus ();

  instr_fetch_mem #(.INSTR_W(16), .CELL_W(8), .DEPTH(256), .NOP(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    tick();
    bus.fetch_req  = 1'b0;
  endtask

  task automatic check_fetch(input string tag, input logic [15:0] ins, input logic [1:0] fc);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "_fault"}, 32'(bus.fault_code), 32'(fc));
    check({tag, "_instr"}, 32'(bus.instr), 32'(ins));
  endtask

  initial begin
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.load_last   = 1'b0;
    bus.reload      = 1'b0;
    bus.fetch_req   = 1'b0;
    bus.fetch_addr  = '0;
    bus.fetch_stall = 1'b0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_load_ready", 32'(bus.load_ready), 32'd1);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_prog_len", 32'(bus.prog_len), 32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_fault", 32'(bus.fault_code), 32'd0);
    check("rst_instr", 32'(bus.instr), 32'h0000);

    // Test 1: small program, aligned fetches
    load_byte(8'h06, 1'b0);
    load_byte(8'h20, 1'b0);
    load_byte(8'h31, 1'b0);
    check("t1_not_running_yet", 32'(bus.running), 32'd0);
    load_byte(8'h06, 1'b1);
    check("t1_prog_len", 32'(bus.prog_len), 32'd4);
    check("t1_running", 32'(bus.running), 32'd1);
    check("t1_load_ready", 32'(bus.load_ready), 32'd0);
    fetch(8'd0);
    check_fetch("t1_f0", 16'h0620, 2'b00);
    fetch(8'd2);
    check_fetch("t1_f2", 16'h3106, 2'b00);
    tick();
    check("t1_idle_valid", 32'(bus.instr_valid), 32'd0);
    check("t1_idle_instr_hold", 32'(bus.instr), 32'h3106);

    // Test 2: faults
    fetch(8'd1);
    check_fetch("t2_misalign", 16'h0000, 2'b01);
    fetch(8'd4);
    check_fetch("t2_range", 16'h0000, 2'b10);
    fetch(8'd3);
    check_fetch("t2_misalign_first", 16'h0000, 2'b01);
    fetch(8'd2);
    check_fetch("t2_ok", 16'h3106, 2'b00);

    // Test 3: stall holds outputs while fetch_req/addr toggle
    fetch(8'd0);
    check_fetch("t3_f0", 16'h0620, 2'b00);
    bus.fetch_stall = 1'b1;
    bus.fetch_req   = 1'b1;
    bus.fetch_addr  = 8'd2;
    tick();
    check_fetch("t3_stall1", 16'h0620, 2'b00);
    bus.fetch_addr = 8'd1;
    tick();
    check_fetch("t3_stall2", 16'h0620, 2'b00);
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = 8'd4;
    tick();
    check_fetch("t3_stall3", 16'h0620, 2'b00);
    bus.fetch_stall = 1'b0;
    fetch(8'd2);
    check_fetch("t3_release", 16'h3106, 2'b00);

    // Test 6: reload together with fetch_req, then fetch during LOAD
    bus.reload     = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'd0;
    tick();
    bus.reload    = 1'b0;
    bus.fetch_req = 1'b0;
    check_fetch("t6_reload", 16'h0000, 2'b11);
    check("t6_load_ready", 32'(bus.load_ready), 32'd1);
    check("t6_prog_len", 32'(bus.prog_len), 32'd0);
    check("t6_running", 32'(bus.running), 32'd0);
    fetch(8'd0);
    check_fetch("t6_fetch_in_load", 16'h0000, 2'b11);
    tick();
    check("t6_idle_valid", 32'(bus.instr_valid), 32'd0);

    // Test 4: full-depth load with random gaps and no load_last
    for (int i = 0; i < 256; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      if (i == 255) check("t4_not_running_255", 32'(bus.running), 32'd0);
      load_byte(8'(i), 1'b0);
    end
    check("t4_running", 32'(bus.running), 32'd1);
    check("t4_prog_len", 32'(bus.prog_len), 32'd256);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hEE;
    tick();
    bus.load_valid = 1'b0;
    check("t4_prog_len_after_ignored", 32'(bus.prog_len), 32'd256);
    fetch(8'd254);
    check_fetch("t4_f254", 16'hFEFF, 2'b00);
    fetch(8'd0);
    check_fetch("t4_f0", 16'h0001, 2'b00);
    fetch(8'd100);
    check_fetch("t4_f100", 16'h6465, 2'b00);

    // Test 5: reset mid-load, then reload a short program
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    check("t5_reload_valid", 32'(bus.instr_valid), 32'd0);
    check("t5_reload_ready", 32'(bus.load_ready), 32'd1);
    load_byte(8'h11, 1'b0);
    load_byte(8'h22, 1'b0);
    load_byte(8'h33, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_prog_len", 32'(bus.prog_len), 32'd0);
    check("t5_rst_load_ready", 32'(bus.load_ready), 32'd1);
    check("t5_rst_running", 32'(bus.running), 32'd0);
    load_byte(8'hAB, 1'b0);
    load_byte(8'hCD, 1'b1);
    check("t5_prog_len", 32'(bus.prog_len), 32'd2);
    fetch(8'd0);
    check_fetch("t5_f0", 16'hABCD, 2'b00);
    fetch(8'd2);
    check_fetch("t5_f2_range", 16'h0000, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
